systolic_ws_array_db: RTL and testbench

Weight-stationary systolic matrix-vector engine. ROWS x COLS grid of MAC cells with double-buffered weights, built-in input skew and output deskew, and signed/unsigned mode. The host streams unskewed activation vectors and receives aligned result vectors at a fixed latency. Sits between the activation buffer and the accumulator/requant stage in the CNN datapath.

---
 rtl/systolic_ws_array_db.sv | 192 +++++++++++++++++++
 tb/tb_systolic_ws_array_db.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ws_array_db.sv
// Weight-stationary ROWS x COLS systolic matrix-vector engine with double-buffered
// weights, built-in activation skew and result deskew, signed/unsigned operands.
module systolic_ws_array_db #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int IN_W  = 8,
  parameter int ACC_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_w_vld,
  input  logic [$clog2(ROWS)-1:0]   i_w_row,
  input  logic [COLS*IN_W-1:0]      i_w_data,
  input  logic                      i_w_swap,
  output logic                      o_swap_err,
  input  logic                      i_signed,
  input  logic                      i_a_vld,
  input  logic [ROWS*IN_W-1:0]      i_a_data,
  output logic                      o_y_vld,
  output logic [COLS*ACC_W-1:0]     o_y_data,
  output logic                      o_busy
);
  localparam int CW = $clog2(ROWS + COLS + 2);
  localparam int XW = ACC_W + 2;

  // Product of two IN_W+1 bit signed views covers both modes; the sum wraps mod 2^ACC_W.
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] psum,
                                           input logic [IN_W-1:0]  a,
                                           input logic [IN_W-1:0]  w,
                                           input logic             sgn);
    logic signed [IN_W:0] ax, wx;
    logic signed [XW-1:0] prod;
    ax   = {sgn & a[IN_W-1], a};
    wx   = {sgn & w[IN_W-1], w};
    prod = XW'(ax) * XW'(wx);
    return psum + prod[ACC_W-1:0];
  endfunction

  logic [IN_W-1:0]  wbank [2][ROWS][COLS];
  logic             act;
  logic [CW-1:0]    cnt;
  logic             swap_ok;

  logic [IN_W-1:0]  a_p0 [ROWS][ROWS-1];
  logic [ROWS-2:0]  vld_p0, sgn_p0;
  logic [IN_W-1:0]  lane_a [ROWS];
  logic [ROWS-1:0]  lane_v, lane_s;

  logic [IN_W-1:0]  a_p1    [ROWS][COLS];
  logic [ACC_W-1:0] psum_p1 [ROWS][COLS];
  logic             vld_p1  [ROWS][COLS];
  logic             sgn_p1  [ROWS][COLS];
  logic [IN_W-1:0]  a_in    [ROWS][COLS];
  logic [ACC_W-1:0] p_in    [ROWS][COLS];
  logic             v_in    [ROWS][COLS];
  logic             s_in    [ROWS][COLS];

  logic [ACC_W-1:0] psum_p2 [COLS][COLS-1];
  logic [COLS-2:0]  vld_p2;
  logic [ACC_W-1:0] y_col   [COLS];

  assign swap_ok = i_w_swap && (cnt == '0) && !i_a_vld;
  assign o_busy  = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      act        <= 1'b0;
      cnt        <= '0;
      o_swap_err <= 1'b0;
    end else begin
      o_swap_err <= i_w_swap && !swap_ok;
      if (swap_ok) act <= ~act;
      if (i_a_vld && !o_y_vld)      cnt <= cnt + CW'(1);
      else if (!i_a_vld && o_y_vld) cnt <= cnt - CW'(1);
    end
  end

  // Writes always target the bank that is inactive during this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) wbank[b][r][c] <= '0;
    end else if (i_w_vld) begin
      for (int c = 0; c < COLS; c++) wbank[~act][i_w_row][c] <= i_w_data[c*IN_W +: IN_W];
    end
  end

  // Stage p0: input skew, lane r delayed r cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      sgn_p0 <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < ROWS-1; k++) a_p0[r][k] <= '0;
    end else begin
      vld_p0[0] <= i_a_vld;
      if (i_a_vld) begin
        sgn_p0[0] <= i_signed;
        for (int r = 0; r < ROWS; r++) a_p0[r][0] <= i_a_data[r*IN_W +: IN_W];
      end
      for (int k = 1; k < ROWS-1; k++) begin
        vld_p0[k] <= vld_p0[k-1];
        if (vld_p0[k-1]) begin
          sgn_p0[k] <= sgn_p0[k-1];
          for (int r = 0; r < ROWS; r++) a_p0[r][k] <= a_p0[r][k-1];
        end
      end
    end
  end

  always_comb begin
    lane_a[0] = i_a_data[IN_W-1:0];
    lane_v[0] = i_a_vld;
    lane_s[0] = i_signed;
    for (int r = 1; r < ROWS; r++) begin
      lane_a[r] = a_p0[r][r-1];
      lane_v[r] = vld_p0[r-1];
      lane_s[r] = sgn_p0[r-1];
    end
    for (int r = 0; r < ROWS; r++) begin
      a_in[r][0] = lane_a[r];
      v_in[r][0] = lane_v[r];
      s_in[r][0] = lane_s[r];
      for (int c = 1; c < COLS; c++) begin
        a_in[r][c] = a_p1[r][c-1];
        v_in[r][c] = vld_p1[r][c-1];
        s_in[r][c] = sgn_p1[r][c-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      p_in[0][c] = '0;
      for (int r = 1; r < ROWS; r++) p_in[r][c] = psum_p1[r-1][c];
    end
  end

  // Stage p1: MAC grid, activations move right and partial sums move down
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          vld_p1[r][c]  <= 1'b0;
          sgn_p1[r][c]  <= 1'b0;
          a_p1[r][c]    <= '0;
          psum_p1[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          vld_p1[r][c] <= v_in[r][c];
          if (v_in[r][c]) begin
            a_p1[r][c]    <= a_in[r][c];
            sgn_p1[r][c]  <= s_in[r][c];
            psum_p1[r][c] <= mac(p_in[r][c], a_in[r][c], wbank[act][r][c], s_in[r][c]);
          end
        end
    end
  end

  // Stage p2: deskew, column c delayed COLS-1-c cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= '0;
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < COLS-1; k++) psum_p2[c][k] <= '0;
    end else begin
      vld_p2[0] <= vld_p1[ROWS-1][0];
      for (int k = 1; k < COLS-1; k++) vld_p2[k] <= vld_p2[k-1];
      for (int c = 0; c < COLS; c++) begin
        psum_p2[c][0] <= psum_p1[ROWS-1][c];
        for (int k = 1; k < COLS-1; k++) psum_p2[c][k] <= psum_p2[c][k-1];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < COLS-1; c++) y_col[c] = psum_p2[c][COLS-2-c];
    y_col[COLS-1] = psum_p1[ROWS-1][COLS-1];
  end

  // Output register holds its value between result vectors
  always_ff @(posedge clk) begin
    if (rst) begin
      o_y_vld  <= 1'b0;
      o_y_data <= '0;
    end else begin
      o_y_vld <= vld_p2[COLS-2];
      if (vld_p2[COLS-2])
        for (int c = 0; c < COLS; c++) o_y_data[c*ACC_W +: ACC_W] <= y_col[c];
    end
  end
endmodule

// File: tb/tb_systolic_ws_array_db.sv
// Bench for systolic_ws_array_db: directed vector table, hand-written corner sequences
// and randomized traffic checked every cycle against a timed matrix-vector reference.
module tb_systolic_ws_array_db;
  localparam int ROWS = 4, COLS = 4, IN_W = 8, ACC_W = 24;
  localparam int LAT = ROWS + COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1, w_vld = 1'b0, w_swap = 1'b0, sgn = 1'b0, a_vld = 1'b0;
  logic [1:0]  w_row = '0;
  logic [31:0] w_data = '0, a_data = '0;
  logic        swap_err, y_vld, busy, swap_err16, y_vld16, busy16;
  logic [95:0] y_data;
  logic [63:0] y_data16;

  always #5 clk = ~clk;

  systolic_ws_array_db #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .i_w_vld(w_vld), .i_w_row(w_row), .i_w_data(w_data),
    .i_w_swap(w_swap), .o_swap_err(swap_err), .i_signed(sgn), .i_a_vld(a_vld),
    .i_a_data(a_data), .o_y_vld(y_vld), .o_y_data(y_data), .o_busy(busy));

  systolic_ws_array_db #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .i_w_vld(w_vld), .i_w_row(w_row), .i_w_data(w_data),
    .i_w_swap(w_swap), .o_swap_err(swap_err16), .i_signed(sgn), .i_a_vld(a_vld),
    .i_a_data(a_data), .o_y_vld(y_vld16), .o_y_data(y_data16), .o_busy(busy16));

  typedef struct { int due; logic [95:0] y; logic [63:0] y16; } exp_t;
  typedef struct { int wsel; logic [31:0] a; bit s; logic [95:0] y; } vec_t;

  exp_t        q[$];
  logic [7:0]  mw [2][ROWS][COLS];
  bit          m_act, m_busy, exp_err, err_seen;
  logic [95:0] held, last_y;
  logic [63:0] held16, last_y16;
  int          tests, fails, now, n_seen;

  function automatic longint ext(input logic [7:0] v, input bit s);
    if (s) return longint'($signed(v));
    return longint'(v);
  endfunction

  function automatic void ref_y(input logic [31:0] a, input bit s,
                                output logic [95:0] y, output logic [63:0] y16);
    for (int c = 0; c < COLS; c++) begin
      longint acc = 0;
      for (int r = 0; r < ROWS; r++) acc += ext(a[r*8 +: 8], s) * ext(mw[m_act][r][c], s);
      y[c*24 +: 24]   = acc[23:0];
      y16[c*16 +: 16] = acc[15:0];
    end
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, now, got, exp);
    end
  endtask

  // One clock: update the reference from this cycle's inputs, then check the next cycle.
  task automatic cyc();
    bit ok, ev;
    exp_t e;
    if (rst) begin
      q.delete();
      foreach (mw[b, r, c]) mw[b][r][c] = '0;
      m_act = 1'b0; exp_err = 1'b0; held = '0; held16 = '0;
    end else begin
      ok = w_swap && !m_busy && !a_vld;
      exp_err = w_swap && !ok;
      if (a_vld) begin
        e.due = now + LAT;
        ref_y(a_data, sgn, e.y, e.y16);
        q.push_back(e);
      end
      if (w_vld) for (int c = 0; c < COLS; c++) mw[!m_act][w_row][c] = w_data[c*8 +: 8];
      if (ok) m_act = !m_act;
    end
    @(posedge clk);
    now++;
    #1;
    ev = (q.size() > 0) && (q[0].due == now);
    m_busy = (q.size() != 0);
    chk("y_vld", y_vld, ev);
    if (y_vld) begin n_seen++; last_y = y_data; end
    if (y_vld16) last_y16 = y_data16;
    if (swap_err) err_seen = 1'b1;
    if (ev) begin held = q[0].y; held16 = q[0].y16; void'(q.pop_front()); end
    chk("y_data", y_data, held);
    chk("y_data16", y_data16, held16);
    chk("swap_err", swap_err, exp_err);
    chk("busy", busy, m_busy);
    chk("inst16_ctrl", {y_vld16, swap_err16, busy16}, {ev, exp_err, m_busy});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    a_vld = 0; w_vld = 0; w_swap = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic load_row(input int r, input logic [31:0] d);
    w_vld = 1; w_row = r[1:0]; w_data = d;
    cyc();
    w_vld = 0;
  endtask

  task automatic do_swap();
    w_swap = 1;
    cyc();
    w_swap = 0;
  endtask

  task automatic send(input logic [31:0] a, input bit s);
    a_vld = 1; a_data = a; sgn = s;
    cyc();
    a_vld = 0;
  endtask

  vec_t tbl[7];
  int   cur, base;

  initial begin
    tests = 0; fails = 0; now = 0; n_seen = 0; m_busy = 0; err_seen = 0;
    m_act = 0; exp_err = 0; held = '0; held16 = '0; last_y = '0; last_y16 = '0;
    foreach (mw[b, r, c]) mw[b][r][c] = '0;

    tbl[0] = '{0, 32'h04030201, 1'b0, {24'd4, 24'd3, 24'd2, 24'd1}};
    tbl[1] = '{0, 32'h000180FF, 1'b1, {24'd0, 24'd1, 24'hFFFF80, 24'hFFFFFF}};
    tbl[2] = '{0, 32'h000180FF, 1'b0, {24'd0, 24'd1, 24'd128, 24'd255}};
    tbl[3] = '{1, 32'h04030201, 1'b1, {4{24'hFFFFF6}}};
    tbl[4] = '{1, 32'h04030201, 1'b0, {4{24'd2550}}};
    tbl[5] = '{1, 32'h00000080, 1'b1, {4{24'd128}}};
    tbl[6] = '{1, 32'hFFFFFFFF, 1'b0, {4{24'd260100}}};

    @(negedge clk);
    rst = 1; cyc(); cyc(); rst = 0;
    chk("rst_y_vld", y_vld, 1'b0);
    chk("rst_y_data", y_data, 96'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_swap_err", swap_err, 1'b0);

    cur = -1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wsel != cur) begin
        for (int r = 0; r < ROWS; r++)
          load_row(r, (tbl[i].wsel == 0) ? (32'h1 << (8*r)) : 32'hFFFFFFFF);
        do_swap();
        cur = tbl[i].wsel;
      end
      send(tbl[i].a, tbl[i].s);
      idle(LAT + 1);
      chk($sformatf("tbl%0d", i), last_y, tbl[i].y);
    end
    chk("wrap16", last_y16, {4{16'd63492}});

    // Streaming with a single bubble in the middle
    load_row(0, 32'h04030201);
    for (int r = 1; r < ROWS; r++) load_row(r, 32'h0);
    do_swap();
    base = n_seen;
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) idle(1);
      send(32'(k), 1'b0);
    end
    idle(LAT + 2);
    chk("stream_cnt", n_seen - base, 16);
    chk("stream_last", last_y, {24'd64, 24'd48, 24'd32, 24'd16});

    // Swap attempted while busy, then retried when idle
    for (int r = 0; r < ROWS; r++) load_row(r, 32'h1 << (8*r));
    err_seen = 0;
    send(32'h00000705, 1'b0);
    idle(2);
    do_swap();
    idle(LAT + 2);
    chk("swap_err_seen", err_seen, 1'b1);
    chk("swap_busy_y", last_y, {24'd20, 24'd15, 24'd10, 24'd5});
    err_seen = 0;
    do_swap();
    send(32'h00000705, 1'b0);
    idle(LAT + 1);
    chk("swap_retry_err", err_seen, 1'b0);
    chk("swap_retry_y", last_y, {24'd0, 24'd0, 24'd7, 24'd5});

    // Write and swap in the same cycle: the written row is live afterwards
    w_vld = 1; w_row = 2'd1; w_data = 32'h02020202; w_swap = 1;
    cyc();
    w_vld = 0; w_swap = 0;
    send(32'h00000705, 1'b0);
    idle(LAT + 1);
    chk("wr_swap_y", last_y, {24'd34, 24'd29, 24'd24, 24'd19});

    // Randomized traffic alternating dense and sparse phases
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 40; i++) begin
        a_vld  = ($urandom_range(99) < ((blk % 2) ? 85 : 15));
        a_data = $urandom;
        sgn    = $urandom_range(1);
        w_vld  = ($urandom_range(99) < 25);
        w_row  = 2'($urandom_range(3));
        w_data = $urandom;
        w_swap = ($urandom_range(99) < 20);
        cyc();
      end
    end
    idle(LAT + 2);

    // Reset with five vectors in flight
    for (int r = 0; r < ROWS; r++) load_row(r, 32'h01010101);
    do_swap();
    for (int k = 0; k < 5; k++) send($urandom | 32'h1, 1'b0);
    rst = 1; cyc(); rst = 0;
    base = n_seen;
    idle(LAT + 4);
    chk("rst_mid_no_out", n_seen - base, 0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_data", y_data, 96'd0);
    send(32'h04030201, 1'b0);
    idle(LAT + 1);
    chk("rst_mid_next_cnt", n_seen - base, 1);
    chk("rst_mid_next_y", last_y, 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
